prim_intr_hw_coal: RTL and testbench
====================================

Name: prim_intr_hw_coal

Overview:
Parametrised successor to the flat interrupt-state helper. It adds per-channel level/rising-edge capture, a registered sticky state with software W1C clear and test injection, and per-channel gated outputs. A coalescing engine asserts one aggregated `irq_o` once enough enabled events have accumulated, or once a holdoff timer expires. It sits between peripheral event sources, the register file and the PLIC.

Parameters:
- Width, 8, number of interrupt channels (1..32).
- CntW, 8, coalescing event-counter width.
- TmrW, 16, holdoff timer width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- event_intr_i  in  Width  raw event per channel
- intr_mode_i  in  Width  per channel: 0 = level, 1 = rising edge
- intr_enable_i  in  Width  per-channel enable
- intr_test_i  in  Width  test-injection data
- intr_test_qe_i  in  1  test write strobe
- intr_clear_i  in  Width  W1C clear data
- intr_clear_qe_i  in  1  clear write strobe
- coal_thresh_i  in  CntW  event-count threshold
- coal_timeout_i  in  TmrW  holdoff in cycles; 0 = timer disabled
- irq_ack_i  in  1  software acknowledge of `irq_o`
- intr_state_o  in/out: out  Width  sticky state register
- intr_o  out  Width  intr_state_o & intr_enable_i (combinational)
- irq_o  out  1  coalesced aggregate interrupt (registered)

Behaviour:
- Reset (async, `rst_i` = 1): state, edge-history, counter, timer = 0; FSM = IDLE; `intr_state_o`, `intr_o`, `irq_o` = 0.
- Edge history: `prev_q` <= `event_intr_i` every cycle.
- Channel capture:
  - `raw` = mode ? (event & ~prev_q) : event.
  - `new` = raw | (intr_test_qe_i ? intr_test_i : 0).
- State update:
  - `state_d` = (state_q & ~(intr_clear_qe_i ? intr_clear_i : 0)) | new.
  - Set beats clear in the same cycle.
  - Latency: event in cycle N → `intr_state_o` / `intr_o` in N+1.
- Enabled count:
  - `pend` = popcount(new & intr_enable_i), per cycle.
  - Events on disabled channels still set state but never count.
- Coalescing FSM (`irq_o` = 1 iff FSM is in FIRE):
  - IDLE: if `pend` != 0 → ACCUM, with cnt_q = pend and tmr_q = 0.
  - ACCUM:
    - Each cycle, cnt_q += pend, saturating at all-ones; tmr_q += 1, saturating.
    - → FIRE if cnt_q >= coal_thresh_i, or if coal_timeout_i != 0 and tmr_q >= coal_timeout_i-1.
    - → IDLE if (state_q & intr_enable_i) == 0; firing takes priority.
  - FIRE: hold `irq_o`. On `irq_ack_i` → IDLE, clear cnt and tmr. If all enabled state is cleared → IDLE.
- Threshold behaviour: a threshold of 0 or 1 fires 2 cycles after the event; `irq_o` rises in N+2.
- Re-trigger rules:
  - After ack, still-pending state does not retrigger `irq_o`; only new enabled events do.
  - `intr_o` stays valid throughout.
- `irq_ack_i` outside FIRE is ignored.
- Events arriving in FIRE update state but are not counted.
- Threshold and timeout inputs are sampled live; changing them mid-ACCUM takes effect in the next compare.
- Reset mid-operation aborts to IDLE. A level held high on an edge channel across reset is captured as a new edge, because `prev_q` = 0.

Decomposition:
- Package `prim_intr_pkg`:
  - `intr_mode_e` {IntrLevel = 0, IntrEdge = 1}
  - `coal_state_e` {CoalIdle, CoalAccum, CoalFire}
  - popcount function
- Sub-module `prim_intr_coalesce`: FSM, counter and timer. It takes `pend`, the any-enabled-pending flag, thresh, timeout and ack, and produces `irq_o`.

Test Plan:
1. Level mode, thresh=4, timeout=0, enable=0x01; 1-cycle pulses on ch0 at cycles 0, 2, 4, 6 → `intr_state_o`[0]=1 from cycle 1; cnt reaches 4 at cycle 7; `irq_o`=1 at cycle 8.
2. thresh=255, timeout=10; single pulse ch3 (enabled) at cycle 0 → ACCUM at 1; `irq_o`=1 at cycle 11; `irq_ack_i` at 15 → `irq_o`=0 at 16, `intr_o`[3] still 1.
3. Edge mode ch2, held high 20 cycles, thresh=2, timeout=0 → state[2] set once; cnt=1; `irq_o` never asserts; clearing ch2 returns FSM to IDLE.
4. `intr_clear_qe_i` with clear=0x04 in the same cycle as an event on ch2 → state[2] remains 1. Clear alone, next cycle → state[2]=0.
5. `intr_test_qe_i`, test=0xF0, enable=0x30, thresh=2 → state=0xF0; pend=2; `irq_o` at N+2; `intr_o`=0x30.
6. `rst_i` asserted during ACCUM with event held high on an edge channel → all outputs 0 immediately. After release, that channel captures a new edge and ACCUM restarts with cnt=1.

Source files
------------

// File: rtl/prim_intr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prim_intr_pkg
// Brief    : Shared types and helpers for the coalescing interrupt block.
// Revision : 1.0 - initial release
// ============================================================================
package prim_intr_pkg;

    typedef enum logic {
        IntrLevel = 1'b0,
        IntrEdge  = 1'b1
    } intr_mode_e;

    typedef enum logic [1:0] {
        CoalIdle  = 2'd0,
        CoalAccum = 2'd1,
        CoalFire  = 2'd2
    } coal_state_e;

    localparam int unsigned c_max_width = 32;
    localparam int unsigned c_pend_w    = 6;

    function automatic logic [c_pend_w-1:0] popcount(input logic [c_max_width-1:0] vec);
        logic [c_pend_w-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < c_max_width; i++) begin
            cnt = cnt + c_pend_w'(vec[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prim_intr_coalesce.sv
`default_nettype none
// ============================================================================
// Module   : prim_intr_coalesce
// Brief    : Event-count / holdoff-timer engine driving the aggregate irq.
// Revision : 1.0 - initial release
// ============================================================================
module prim_intr_coalesce
    import prim_intr_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TMR_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [c_pend_w-1:0] pend_i,
    input  logic                any_pend_i,
    input  logic [CNT_W-1:0]    thresh_i,
    input  logic [TMR_W-1:0]    timeout_i,
    input  logic                ack_i,
    output logic                irq_o
);

    localparam int unsigned c_sum_w = CNT_W + c_pend_w;
    localparam logic [c_sum_w-1:0] c_cnt_max = c_sum_w'({CNT_W{1'b1}});

    coal_state_e        r_fsm, w_fsm_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
    logic [TMR_W-1:0]   r_tmr, w_tmr_d;
    logic               r_irq;

    logic [c_sum_w-1:0] w_sum_add;
    logic [CNT_W-1:0]   w_cnt_add, w_cnt_new;
    logic [TMR_W-1:0]   w_tmr_inc;
    logic               w_thr_hit, w_tmo_hit;

    // Counter and timer both saturate rather than wrap.
    assign w_sum_add = c_sum_w'(r_cnt) + c_sum_w'(pend_i);
    assign w_cnt_add = (w_sum_add > c_cnt_max) ? '1 : w_sum_add[CNT_W-1:0];
    assign w_cnt_new = (c_sum_w'(pend_i) > c_cnt_max) ? '1 : CNT_W'(pend_i);
    assign w_tmr_inc = (r_tmr == '1) ? r_tmr : r_tmr + TMR_W'(1);

    assign w_thr_hit = (r_cnt >= thresh_i);
    assign w_tmo_hit = (timeout_i != '0) && (r_tmr >= timeout_i - TMR_W'(1));

    always_comb begin
        w_fsm_d = r_fsm;
        w_cnt_d = r_cnt;
        w_tmr_d = r_tmr;
        case (r_fsm)
            CoalIdle: begin
                if (pend_i != '0) begin
                    w_fsm_d = CoalAccum;
                    w_cnt_d = w_cnt_new;
                    w_tmr_d = '0;
                end
            end
            CoalAccum: begin
                w_cnt_d = w_cnt_add;
                w_tmr_d = w_tmr_inc;
                if (w_thr_hit || w_tmo_hit) begin
                    w_fsm_d = CoalFire;
                end else if (!any_pend_i) begin
                    w_fsm_d = CoalIdle;
                    w_cnt_d = '0;
                    w_tmr_d = '0;
                end
            end
            CoalFire: begin
                if (ack_i || !any_pend_i) begin
                    w_fsm_d = CoalIdle;
                    w_cnt_d = '0;
                    w_tmr_d = '0;
                end
            end
            default: begin
                w_fsm_d = CoalIdle;
                w_cnt_d = '0;
                w_tmr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fsm <= CoalIdle;
            r_cnt <= '0;
            r_tmr <= '0;
            r_irq <= 1'b0;
        end else begin
            r_fsm <= w_fsm_d;
            r_cnt <= w_cnt_d;
            r_tmr <= w_tmr_d;
            r_irq <= (w_fsm_d == CoalFire);
        end
    end

    assign irq_o = r_irq;

endmodule
`default_nettype wire

// File: rtl/prim_intr_hw_coal.sv
`default_nettype none
// ============================================================================
// Module   : prim_intr_hw_coal
// Brief    : Per-channel level/edge interrupt state with a coalesced irq.
// Revision : 1.0 - initial release
// ============================================================================
module prim_intr_hw_coal
    import prim_intr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TMR_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] event_intr_i,
    input  logic [WIDTH-1:0] intr_mode_i,
    input  logic [WIDTH-1:0] intr_enable_i,
    input  logic [WIDTH-1:0] intr_test_i,
    input  logic             intr_test_qe_i,
    input  logic [WIDTH-1:0] intr_clear_i,
    input  logic             intr_clear_qe_i,
    input  logic [CNT_W-1:0] coal_thresh_i,
    input  logic [TMR_W-1:0] coal_timeout_i,
    input  logic             irq_ack_i,
    output logic [WIDTH-1:0] intr_state_o,
    output logic [WIDTH-1:0] intr_o,
    output logic             irq_o
);

    logic [WIDTH-1:0]    r_prev, r_state;
    logic [WIDTH-1:0]    w_raw, w_new, w_clr, w_state_d;
    logic [c_pend_w-1:0] w_pend;
    logic                w_any_pend;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        intr_mode_e w_mode;
        assign w_mode   = intr_mode_e'(intr_mode_i[i]);
        assign w_raw[i] = (w_mode == IntrEdge) ? (event_intr_i[i] & ~r_prev[i])
                                               : event_intr_i[i];
    end

    // New captures are ORed in after the clear so a set always wins.
    assign w_new     = w_raw | (intr_test_qe_i ? intr_test_i : '0);
    assign w_clr     = intr_clear_qe_i ? intr_clear_i : '0;
    assign w_state_d = (r_state & ~w_clr) | w_new;

    assign w_pend     = popcount(c_max_width'(w_new & intr_enable_i));
    assign w_any_pend = |(r_state & intr_enable_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prev  <= '0;
            r_state <= '0;
        end else begin
            r_prev  <= event_intr_i;
            r_state <= w_state_d;
        end
    end

    assign intr_state_o = r_state;
    assign intr_o       = r_state & intr_enable_i;

    prim_intr_coalesce #(
        .CNT_W (CNT_W),
        .TMR_W (TMR_W)
    ) u_coalesce (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pend_i     (w_pend),
        .any_pend_i (w_any_pend),
        .thresh_i   (coal_thresh_i),
        .timeout_i  (coal_timeout_i),
        .ack_i      (irq_ack_i),
        .irq_o      (irq_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_prim_intr_hw_coal.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_intr_hw_coal
// Brief    : Directed scoreboard bench for prim_intr_hw_coal.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prim_intr_hw_coal;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  event_intr_i, intr_mode_i, intr_enable_i, intr_test_i, intr_clear_i;
    logic        intr_test_qe_i, intr_clear_qe_i, irq_ack_i;
    logic [7:0]  coal_thresh_i;
    logic [15:0] coal_timeout_i;
    logic [7:0]  intr_state_o, intr_o;
    logic        irq_o;

    prim_intr_hw_coal dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .event_intr_i    (event_intr_i),
        .intr_mode_i     (intr_mode_i),
        .intr_enable_i   (intr_enable_i),
        .intr_test_i     (intr_test_i),
        .intr_test_qe_i  (intr_test_qe_i),
        .intr_clear_i    (intr_clear_i),
        .intr_clear_qe_i (intr_clear_qe_i),
        .coal_thresh_i   (coal_thresh_i),
        .coal_timeout_i  (coal_timeout_i),
        .irq_ack_i       (irq_ack_i),
        .intr_state_o    (intr_state_o),
        .intr_o          (intr_o),
        .irq_o           (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         tag;
        logic [7:0] st;
        logic [7:0] io;
        logic       irq;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   t0;

    task automatic exp_at(input int t, input int tag, input logic [7:0] st,
                          input logic [7:0] io, input logic irq);
        exp_t e;
        e.cyc = t; e.tag = tag; e.st = st; e.io = io; e.irq = irq;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation that falls due in the current cycle.
    always @(negedge clk_i) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (intr_state_o !== sb[i].st || intr_o !== sb[i].io || irq_o !== sb[i].irq) begin
                    failures++;
                    $display("FAIL t%0d.%0d state=%h intr=%h irq=%b required state=%h intr=%h irq=%b",
                             sb[i].tag / 100, sb[i].tag % 100, intr_state_o, intr_o, irq_o,
                             sb[i].st, sb[i].io, sb[i].irq);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL t%0d.%0d sample missed at cycle %0d, now %0d",
                         sb[i].tag / 100, sb[i].tag % 100, sb[i].cyc, cyc);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        event_intr_i = '0; intr_mode_i = '0; intr_enable_i = '0;
        intr_test_i = '0; intr_test_qe_i = 1'b0;
        intr_clear_i = '0; intr_clear_qe_i = 1'b0;
        coal_thresh_i = '0; coal_timeout_i = '0; irq_ack_i = 1'b0;
    endtask

    task automatic pulses_off();
        intr_test_qe_i = 1'b0; intr_clear_qe_i = 1'b0; irq_ack_i = 1'b0;
        intr_test_i = '0; intr_clear_i = '0;
    endtask

    task automatic do_reset(input int test);
        tick();
        clear_inputs();
        rst_i = 1'b1;
        exp_at(cyc, test * 100 + 98, 8'h00, 8'h00, 1'b0);
        tick();
        exp_at(cyc, test * 100 + 99, 8'h00, 8'h00, 1'b0);
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();

        // 1: level ch0 pulses every other cycle, threshold 4
        do_reset(1);
        intr_enable_i = 8'h01; coal_thresh_i = 8'd4;
        t0 = cyc + 1;
        exp_at(t0 + 0, 100, 8'h00, 8'h00, 1'b0);
        exp_at(t0 + 1, 101, 8'h01, 8'h01, 1'b0);
        exp_at(t0 + 7, 107, 8'h01, 8'h01, 1'b0);
        exp_at(t0 + 8, 108, 8'h01, 8'h01, 1'b1);
        exp_at(t0 + 9, 109, 8'h01, 8'h01, 1'b1);
        for (int r = 0; r <= 9; r++) begin
            tick(); pulses_off();
            event_intr_i = (r % 2 == 0 && r <= 6) ? 8'h01 : 8'h00;
        end

        // 2: holdoff timer fires, then ack without retrigger
        do_reset(2);
        intr_enable_i = 8'h08; coal_thresh_i = 8'd255; coal_timeout_i = 16'd10;
        t0 = cyc + 1;
        exp_at(t0 + 10, 210, 8'h08, 8'h08, 1'b0);
        exp_at(t0 + 11, 211, 8'h08, 8'h08, 1'b1);
        exp_at(t0 + 15, 215, 8'h08, 8'h08, 1'b1);
        exp_at(t0 + 16, 216, 8'h08, 8'h08, 1'b0);
        exp_at(t0 + 20, 220, 8'h08, 8'h08, 1'b0);
        for (int r = 0; r <= 20; r++) begin
            tick(); pulses_off();
            event_intr_i = (r == 0) ? 8'h08 : 8'h00;
            irq_ack_i    = (r == 15);
        end

        // 3: edge ch2 held high counts once; clear returns FSM to idle
        do_reset(3);
        intr_mode_i = 8'h04; intr_enable_i = 8'h04; coal_thresh_i = 8'd2;
        t0 = cyc + 1;
        exp_at(t0 + 1,  301, 8'h04, 8'h04, 1'b0);
        exp_at(t0 + 10, 310, 8'h04, 8'h04, 1'b0);
        exp_at(t0 + 20, 320, 8'h04, 8'h04, 1'b0);
        exp_at(t0 + 23, 323, 8'h00, 8'h00, 1'b0);
        exp_at(t0 + 26, 326, 8'h04, 8'h04, 1'b0);
        exp_at(t0 + 27, 327, 8'h04, 8'h04, 1'b0);
        exp_at(t0 + 28, 328, 8'h04, 8'h04, 1'b0);
        for (int r = 0; r <= 28; r++) begin
            tick(); pulses_off();
            event_intr_i = (r < 20 || r == 25) ? 8'h04 : 8'h00;
            if (r == 22) begin intr_clear_qe_i = 1'b1; intr_clear_i = 8'h04; end
        end

        // 4: set beats clear in the same cycle; clear alone wins next
        do_reset(4);
        intr_enable_i = 8'h04; coal_thresh_i = 8'd255;
        t0 = cyc + 1;
        exp_at(t0 + 1, 401, 8'h04, 8'h04, 1'b0);
        exp_at(t0 + 2, 402, 8'h04, 8'h04, 1'b0);
        exp_at(t0 + 3, 403, 8'h04, 8'h04, 1'b0);
        exp_at(t0 + 4, 404, 8'h00, 8'h00, 1'b0);
        for (int r = 0; r <= 4; r++) begin
            tick(); pulses_off();
            event_intr_i = (r == 0 || r == 2) ? 8'h04 : 8'h00;
            if (r == 2 || r == 3) begin intr_clear_qe_i = 1'b1; intr_clear_i = 8'h04; end
        end

        // 5: test injection, two enabled channels reach threshold 2
        do_reset(5);
        intr_enable_i = 8'h30; coal_thresh_i = 8'd2;
        t0 = cyc + 1;
        exp_at(t0 + 1, 501, 8'hF0, 8'h30, 1'b0);
        exp_at(t0 + 2, 502, 8'hF0, 8'h30, 1'b1);
        exp_at(t0 + 3, 503, 8'hF0, 8'h30, 1'b1);
        for (int r = 0; r <= 3; r++) begin
            tick(); pulses_off();
            if (r == 0) begin intr_test_qe_i = 1'b1; intr_test_i = 8'hF0; end
        end

        // 6: reset mid-accumulate, held edge recaptured, live threshold change
        do_reset(6);
        intr_mode_i = 8'h02; intr_enable_i = 8'h02; coal_thresh_i = 8'd2;
        t0 = cyc + 1;
        exp_at(t0 + 2, 602, 8'h02, 8'h02, 1'b0);
        exp_at(t0 + 3, 603, 8'h00, 8'h00, 1'b0);
        exp_at(t0 + 4, 604, 8'h00, 8'h00, 1'b0);
        exp_at(t0 + 5, 605, 8'h00, 8'h00, 1'b0);
        exp_at(t0 + 6, 606, 8'h02, 8'h02, 1'b0);
        exp_at(t0 + 7, 607, 8'h02, 8'h02, 1'b0);
        exp_at(t0 + 8, 608, 8'h02, 8'h02, 1'b0);
        exp_at(t0 + 9, 609, 8'h02, 8'h02, 1'b1);
        for (int r = 0; r <= 9; r++) begin
            tick(); pulses_off();
            event_intr_i = 8'h02;
            if (r == 3) rst_i = 1'b1;
            if (r == 5) rst_i = 1'b0;
            if (r == 8) coal_thresh_i = 8'd1;
        end

        tick(); tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
